// File: rtl/keycode_ctrl_if.sv
// Purpose : bundles the keyboard/vsync inputs and the per-frame control
//           outputs of keycode_ctrl into one port.
// Ports   : keycode0/vsync driven by the master (keyboard + video side);
//           frame_tick, move_*, jump_pulse, paused, rollover_err driven by
//           the slave (keycode_ctrl).
interface keycode_ctrl_if;
  logic [31:0] keycode0;
  logic        vsync;
  logic        frame_tick;
  logic        move_left;
  logic        move_right;
  logic        move_up;
  logic        move_down;
  logic        jump_pulse;
  logic        paused;
  logic        rollover_err;

  modport master (
    output keycode0, vsync,
    input  frame_tick, move_left, move_right, move_up, move_down,
           jump_pulse, paused, rollover_err
  );

  modport slave (
    input  keycode0, vsync,
    output frame_tick, move_left, move_right, move_up, move_down,
           jump_pulse, paused, rollover_err
  );
endinterface

// File: rtl/keycode_ctrl.sv
// Purpose : turns USB HID keycodes into frame-sampled game controls
//           (direction levels, jump command with cooldown, pause toggle).
// Latency : outputs update on the frame_tick edge, 3 Clk edges after the raw
//           vsync transition into its active level.
// Backpr. : none; this is a free-running sampler with no flow control.
// Ports   : Clk, reset_rtl_0 (async, active-low); bus.keycode0/bus.vsync in,
//           bus.frame_tick/move_*/jump_pulse/paused/rollover_err out.
module keycode_ctrl #(
  parameter int VS_ACTIVE_LOW = 1,
  parameter int JUMP_COOLDOWN = 8
) (
  input  logic                 Clk,
  input  logic                 reset_rtl_0,
  keycode_ctrl_if.slave        bus
);

  localparam logic       VS_IDLE = (VS_ACTIVE_LOW != 0);
  localparam logic [7:0] CD_LOAD = JUMP_COOLDOWN[7:0];

  typedef enum logic {READY, COOLDOWN} jstate_t;

  // vsync synchroniser (meta, sync) plus one extra stage for edge detection
  logic       vs_meta_q, vs_sync_q, vs_prev_q;
  logic       frame_tick_q, jump_pulse_q, paused_q, rollover_err_q;
  logic       move_left_q, move_right_q, move_up_q, move_down_q;
  logic       pause_prev_q, jump_prev_q;
  logic [7:0] cnt_q;
  jstate_t    jstate_q;

  logic       tick_fire;
  logic       k_left, k_right, k_up, k_down, k_jump, k_pause, k_roll;
  logic [7:0] kbyte;
  logic       paused_d;

  assign tick_fire = (vs_sync_q != VS_IDLE) && (vs_prev_q == VS_IDLE);

  // Raw key flags: any of the four slots may hold a key, duplicates OR together
  always_comb begin
    k_left  = 1'b0;
    k_right = 1'b0;
    k_up    = 1'b0;
    k_down  = 1'b0;
    k_jump  = 1'b0;
    k_pause = 1'b0;
    k_roll  = 1'b0;
    kbyte   = 8'h00;
    for (int i = 0; i < 4; i++) begin
      kbyte = bus.keycode0[8*i +: 8];
      if (kbyte == 8'h04 || kbyte == 8'h50) k_left  = 1'b1;
      if (kbyte == 8'h07 || kbyte == 8'h4F) k_right = 1'b1;
      if (kbyte == 8'h1A || kbyte == 8'h52) k_up    = 1'b1;
      if (kbyte == 8'h16 || kbyte == 8'h51) k_down  = 1'b1;
      if (kbyte == 8'h2C)                   k_jump  = 1'b1;
      if (kbyte == 8'h13)                   k_pause = 1'b1;
      if (kbyte == 8'h01)                   k_roll  = 1'b1;
    end
  end

  // Pause toggles on a press edge; the new value already masks this frame
  assign paused_d = paused_q ^ (k_pause & ~pause_prev_q);

  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      vs_meta_q      <= VS_IDLE;
      vs_sync_q      <= VS_IDLE;
      vs_prev_q      <= VS_IDLE;
      frame_tick_q   <= 1'b0;
      jump_pulse_q   <= 1'b0;
      paused_q       <= 1'b0;
      rollover_err_q <= 1'b0;
      move_left_q    <= 1'b0;
      move_right_q   <= 1'b0;
      move_up_q      <= 1'b0;
      move_down_q    <= 1'b0;
      pause_prev_q   <= 1'b0;
      jump_prev_q    <= 1'b0;
      cnt_q          <= 8'd0;
      jstate_q       <= READY;
    end else begin
      vs_meta_q    <= bus.vsync;
      vs_sync_q    <= vs_meta_q;
      vs_prev_q    <= vs_sync_q;
      frame_tick_q <= tick_fire;
      jump_pulse_q <= 1'b0;
      if (tick_fire) begin
        if (k_roll) begin
          // Rollover frame: report it, everything else keeps last frame's view
          rollover_err_q <= 1'b1;
        end else begin
          rollover_err_q <= 1'b0;
          pause_prev_q   <= k_pause;
          jump_prev_q    <= k_jump;
          paused_q       <= paused_d;
          move_left_q    <= k_left  & ~k_right & ~paused_d;
          move_right_q   <= k_right & ~k_left  & ~paused_d;
          move_up_q      <= k_up    & ~k_down  & ~paused_d;
          move_down_q    <= k_down  & ~k_up    & ~paused_d;
          if (!paused_d) begin
            case (jstate_q)
              READY: begin
                if (k_jump && !jump_prev_q) begin
                  jump_pulse_q <= 1'b1;
                  cnt_q        <= CD_LOAD;
                  jstate_q     <= COOLDOWN;
                end
              end
              COOLDOWN: begin
                // Jump edges here are dropped, not queued
                cnt_q <= cnt_q - 8'd1;
                if (cnt_q <= 8'd1) jstate_q <= READY;
              end
              default: jstate_q <= READY;
            endcase
          end
        end
      end
    end
  end

  assign bus.frame_tick   = frame_tick_q;
  assign bus.jump_pulse   = jump_pulse_q;
  assign bus.paused       = paused_q;
  assign bus.rollover_err = rollover_err_q;
  assign bus.move_left    = move_left_q;
  assign bus.move_right   = move_right_q;
  assign bus.move_up      = move_up_q;
  assign bus.move_down    = move_down_q;

endmodule

// File: doc/keycode_ctrl.md
KEYCODE_CTRL -- requirements
Module: keycode_ctrl

Interface
REQ-001 SHALL have parameter VS_ACTIVE_LOW, default 1, meaning vsync pulse polarity (1 = active-low).
REQ-002 SHALL have parameter JUMP_COOLDOWN, default 8, meaning frames (1..255) before another jump is accepted.
REQ-003 SHALL have port Clk  input  1  100 MHz system clock; one clock; all state is in this domain.
REQ-004 SHALL have port reset_rtl_0  input  1  reset; reset is asynchronous and active-low.
REQ-005 SHALL have port keycode0  input  32  four USB HID keycodes, one per byte; 0x00 means empty slot.
REQ-006 SHALL have port vsync  input  1  VGA vsync from the 25 MHz pixel domain; asynchronous to Clk.
REQ-007 SHALL have port frame_tick  output  1  one-Clk pulse per frame.
REQ-008 SHALL have port move_left, move_right, move_up, move_down  output  1 each  frame-sampled direction levels.
REQ-009 SHALL have port jump_pulse  output  1  one-Clk jump command.
REQ-010 SHALL have port paused  output  1  pause state level.
REQ-011 SHALL have port rollover_err  output  1  HID rollover error seen in the current frame.

Function
REQ-012 SHALL synchronise vsync through two Clk flops before any use.
REQ-013 SHALL detect the synchronised vsync edge into its active level (falling edge if VS_ACTIVE_LOW=1, else rising) and register frame_tick=1 for exactly one Clk cycle, 3 Clk edges after the raw vsync transition.
REQ-014 SHALL decode raw key flags combinationally from any byte of keycode0: left 0x04 or 0x50, right 0x07 or 0x4F, up 0x1A or 0x52, down 0x16 or 0x51, jump 0x2C, pause 0x13; byte order irrelevant; duplicates equal a single match.
REQ-015 SHALL sample raw flags only at the Clk edge that sets frame_tick; all level outputs and jump_pulse update on that same edge and are stable until the next frame_tick.
REQ-016 SHALL drive both move_left and move_right to 0 when both are pressed; likewise for up/down.
REQ-017 SHALL treat any byte equal to 0x01 (ErrorRollOver) as a rollover frame: rollover_err=1 for that frame; direction outputs, paused, jump FSM and previous-sample registers hold their prior values.
REQ-018 SHALL toggle paused when pause is sampled 1 and was sampled 0 at the previous non-rollover frame_tick; holding P toggles once.
REQ-019 SHALL force all four direction outputs to 0 while paused=1, including in the frame in which paused becomes 1.
REQ-020 SHALL implement the jump FSM with states READY and COOLDOWN and an 8-bit frame counter.
REQ-021 In READY, a jump rising edge (sampled 1, previous 0) with paused=0 SHALL assert jump_pulse for one Clk cycle, load counter=JUMP_COOLDOWN and go to COOLDOWN.
REQ-022 In COOLDOWN, each non-rollover, unpaused frame_tick SHALL decrement the counter; the tick that decrements it to 0 returns the FSM to READY; jump edges during COOLDOWN are dropped and not queued.
REQ-023 While paused=1, the FSM and counter SHALL freeze and jump_pulse SHALL stay 0.
REQ-024 A held jump key SHALL never retrigger; a release frame followed by a press frame is required.
REQ-025 With no vsync edges, all outputs SHALL hold indefinitely and keycode0 changes SHALL have no output effect.

Reset
REQ-026 On reset_rtl_0=0 all outputs SHALL go to 0 immediately; FSM=READY, counter=0, previous-sample flags=0, sync flops = vsync inactive level (1 if VS_ACTIVE_LOW=1).
REQ-027 Reset asserted mid-cooldown or mid-pause SHALL fully clear the state; the first frame_tick after release behaves as the first frame.
REQ-028 Deassertion SHALL create no spurious frame_tick while vsync stays inactive.

Verification
REQ-029 keycode0=0x00000004, vsync 1->0 -> frame_tick pulse 3 Clk later; move_left=1, others 0.
REQ-030 keycode0=0x07000400 -> at next frame_tick move_left=0, move_right=0.
REQ-031 keycode0=0x0000002C held 12 frames, JUMP_COOLDOWN=8 -> exactly one jump_pulse; release one frame, press again -> second pulse only at or after frame 9 from the first.
REQ-032 keycode0=0x00001304 for 3 frames -> paused=1 after frame 1 and stays 1; move_left=0; release then press P -> paused=0, move_left=1.
REQ-033 keycode0=0x01010101 after a left-held frame -> rollover_err=1, move_left stays 1; next clean frame rollover_err=0.
REQ-034 Assert reset during COOLDOWN with counter=5 -> all outputs 0; after release the first Space press frame yields jump_pulse=1.
